core_bus_arbiter: RTL

Parametrised N-channel arbiter for the core/cache bus. It merges NCH core-side request channels onto one downstream cache/memory channel, with round-robin grant by default. It tracks outstanding requests in an in-order ID FIFO and steers each multi-beat response burst back to the channel that issued it. It sits between the fetch/data units and the shared cache port, using the same req/reqtag/reqcyc/reqack and resp/resptag/respcyc/respack handshake on both sides.

---
 rtl/core_bus_pkg.sv | 27 ++
 rtl/core_bus_idfifo.sv | 50 +++++
 rtl/core_bus_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/core_bus_pkg.sv
// Shared constants, arbiter state encoding and width helper for the core/cache bus.
package core_bus_pkg;

  localparam logic       READ   = 1'b1;
  localparam logic       WRITE  = 1'b0;

  localparam logic [1:0] MEMORY = 2'd0;
  localparam logic [1:0] MMIO   = 2'd1;
  localparam logic [1:0] PORT   = 2'd2;
  localparam logic [1:0] IRQ    = 2'd3;

  localparam logic       INST   = 1'b0;
  localparam logic       DATA   = 1'b1;

  typedef enum logic {
    IDLE,
    ISSUE
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/core_bus_idfifo.sv
// In-order FIFO of granted channel indices; the head selects the response owner.
module core_bus_idfifo
  import core_bus_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// N-channel request arbiter with in-order response steering onto one cache port.
// Build option: CORE_BUS_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a request and a free ID FIFO slot
// ISSUE | holding the granted request on m_req* until m_reqack
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int NCH        = 2,
  parameter int DEPTH      = 4,
  parameter int RESP_BEATS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH*DATA_WIDTH-1:0] c_req,
  input  logic [NCH*TAG_WIDTH-1:0]  c_reqtag,
  input  logic [NCH-1:0]            c_reqcyc,
  output logic [NCH-1:0]            c_reqack,
  output logic [NCH*DATA_WIDTH-1:0] c_resp,
  output logic [NCH*TAG_WIDTH-1:0]  c_resptag,
  output logic [NCH-1:0]            c_respcyc,
  input  logic [NCH-1:0]            c_respack,
  output logic [DATA_WIDTH-1:0]     m_req,
  output logic [TAG_WIDTH-1:0]      m_reqtag,
  output logic                      m_reqcyc,
  input  logic                      m_reqack,
  input  logic [DATA_WIDTH-1:0]     m_resp,
  input  logic [TAG_WIDTH-1:0]      m_resptag,
  input  logic                      m_respcyc,
  output logic                      m_respack,
  output logic                      err_orphan
);

  localparam int IDW = (clog2(NCH) < 1) ? 1 : clog2(NCH);
  localparam int CW  = clog2(DEPTH+1);
  localparam int BW  = clog2(RESP_BEATS+1);

  arb_state_t     state;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] win;
  logic           found;
  logic [IDW-1:0] head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           issue_ack;
  logic           beat_fire;
  logic           last_beat;
  logic [BW-1:0]  beat;

`ifdef CORE_BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (c_reqcyc[k]) begin
        win   = IDW'(k);
        found = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] rr;

  // Search starts at the channel after the last one served.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && c_reqcyc[(int'(rr) + k) % NCH]) begin
        win   = IDW'((int'(rr) + k) % NCH);
        found = 1'b1;
      end
    end
  end
`endif

  assign issue_ack = (state == ISSUE) && m_reqack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      m_reqcyc <= 1'b0;
      m_req    <= '0;
      m_reqtag <= '0;
`ifndef CORE_BUS_ARB_FIXED_PRIO_EN
      rr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found && (fifo_count < CW'(DEPTH))) begin
            gnt      <= win;
            m_reqcyc <= 1'b1;
            m_req    <= c_req[win*DATA_WIDTH +: DATA_WIDTH];
            m_reqtag <= c_reqtag[win*TAG_WIDTH +: TAG_WIDTH];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_reqack) begin
            m_reqcyc <= 1'b0;
            state    <= IDLE;
`ifndef CORE_BUS_ARB_FIXED_PRIO_EN
            rr       <= (gnt == IDW'(NCH - 1)) ? '0 : gnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    c_reqack = '0;
    if (state == ISSUE) c_reqack[gnt] = m_reqack;
  end

  core_bus_idfifo #(
    .WIDTH (IDW),
    .DEPTH (DEPTH)
  ) u_idfifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue_ack && !fifo_full),
    .pop   (last_beat),
    .din   (gnt),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // With nothing outstanding a response has no owner: never consume it.
  always_comb begin
    c_respcyc = '0;
    m_respack = 1'b0;
    if (!fifo_empty) begin
      c_respcyc[head] = m_respcyc;
      m_respack       = c_respack[head];
    end
  end

  assign c_resp    = {NCH{m_resp}};
  assign c_resptag = {NCH{m_resptag}};

  assign beat_fire = m_respcyc && m_respack;
  assign last_beat = beat_fire && (beat == BW'(RESP_BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      beat       <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (last_beat)      beat <= '0;
      else if (beat_fire) beat <= beat + 1'b1;
      if (m_respcyc && fifo_empty) err_orphan <= 1'b1;
    end
  end

endmodule
